// File: rtl/digct_serial_tx_pkg.sv
// Shared types and constants for the DigCt serial transmitter.
// frame_len() gives the full frame duration in clocks, from start bit through stop bit.
package digct_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic TX_IDLE = 1'b1;

   function automatic int frame_len(input int data_w, input int parity_en,
                                    input int clks_per_bit);
      return (2 + data_w + parity_en) * clks_per_bit;
   endfunction

endpackage

// File: rtl/digct_serial_tx_if.sv
// Word-in / serial-out signal bundle for digct_serial_tx.
// valid/ready: a word is accepted on a rising edge where din_valid and din_ready are both high.
// The source holds din stable until that edge, and the sink samples din only on that edge.
interface digct_serial_tx_if #(
   parameter int DATA_W = 3
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              tx;
   logic              busy;
   logic              frame_done;

   modport master (output din, din_valid, input din_ready, tx, busy, frame_done);
   modport slave  (input din, din_valid, output din_ready, tx, busy, frame_done);
endinterface

// File: rtl/digct_serial_tx_bit_timer.sv
// Bit-period counter: bit_tick marks the last clock of each serial bit,
// and pre_tick marks the clock just before it.
module digct_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic bit_tick,
   output logic pre_tick
);
   localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PRE = (CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0;

   logic [CW-1:0] cnt;

   assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));
   // With one clock per bit, no cycle comes before the last one.
   assign pre_tick = (CLKS_PER_BIT > 1) && (cnt == CW'(PRE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart || bit_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/digct_serial_tx.sv
// UART-style transmitter: start bit, data LSB first, optional even parity, stop bit.
// All serial and status outputs are flops or decode the state register.
module digct_serial_tx
   import digct_pkg::*;
#(
   parameter int DATA_W       = 3,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   digct_serial_tx_if.slave    bus,
   output state_t              state_dbg
);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [BW-1:0]     bit_cnt;
   logic              parity;
   logic              tx_q;
   logic              done_q;
   logic              bit_tick;
   logic              pre_tick;
   logic              accept;

   assign accept         = bus.din_valid && (state == IDLE);
   assign bus.din_ready  = (state == IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.tx         = tx_q;
   assign bus.frame_done = done_q;
   assign state_dbg      = state;

   digct_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .restart  (accept),
      .bit_tick (bit_tick),
      .pre_tick (pre_tick)
   );

   // tx_q is loaded one edge ahead of each bit so the line changes exactly at bit boundaries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx_q    <= TX_IDLE;
         done_q  <= 1'b0;
         shreg   <= '0;
         bit_cnt <= '0;
         parity  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               tx_q <= TX_IDLE;
               if (accept) begin
                  shreg  <= bus.din;
                  parity <= ^bus.din;
                  tx_q   <= ~TX_IDLE;
                  state  <= START;
               end
            end
            START: begin
               if (bit_tick) begin
                  state   <= DATA;
                  tx_q    <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (bit_cnt == BW'(DATA_W - 1)) begin
                     if (PARITY_EN != 0) begin
                        state <= PARITY;
                        tx_q  <= parity;
                     end else begin
                        state  <= STOP;
                        tx_q   <= TX_IDLE;
                        done_q <= (CLKS_PER_BIT == 1);
                     end
                  end else begin
                     tx_q    <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (bit_tick) begin
                  state  <= STOP;
                  tx_q   <= TX_IDLE;
                  done_q <= (CLKS_PER_BIT == 1);
               end
            end
            STOP: begin
               if (bit_tick) begin
                  state <= IDLE;
               end else begin
                  done_q <= pre_tick;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
